row_accumulator: RTL



---
 rtl/row_accumulator_pkg.sv | 29 ++
 rtl/axi_stream_if.sv | 14 +
 rtl/row_accumulator_segment_compactor.sv | 38 +++
 rtl/row_accumulator.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/row_accumulator_pkg.sv
// Shared types and helpers for row_accumulator: FSM state, carry register layout, saturating add.
// ACC_WIDTH fixes the carry/saturation datapath width and must equal the row_accumulator DATA_WIDTH.
package row_acc_pkg;

    localparam int ACC_WIDTH = 32;

    typedef enum logic {
        RUN,
        FLUSH
    } row_acc_state_e;

    typedef struct packed {
        logic                 vld;
        logic [ACC_WIDTH-1:0] row;
        logic [ACC_WIDTH-1:0] sum;
    } carry_t;

    // Signed add clamped to the representable two's-complement range.
    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return s[ACC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Lane-parallel AXI-Stream style interface: valid/ready handshake, per-lane mask, end-of-stream last.
interface axi_stream_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 8
) ();
    logic                                   valid;
    logic                                   ready;
    logic                                   last;
    logic [PARALLELISM-1:0]                 mask;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data;

    modport master (output valid, output last, output mask, output data, input ready);
    modport slave  (input valid, input last, input mask, input data, output ready);
endinterface

// File: rtl/row_accumulator_segment_compactor.sv
// Packs completed segments (flagged by seg_end) contiguously from lane 0, in lane order,
// using a running prefix count of end flags as each segment's output slot.
module segment_compactor
    import row_acc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 9,
    parameter int COUNT_WIDTH = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]                 seg_end,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] seg_row,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] seg_sum,
    output logic [LANES-1:0][DATA_WIDTH-1:0] packed_row,
    output logic [LANES-1:0][DATA_WIDTH-1:0] packed_sum,
    output logic [COUNT_WIDTH-1:0]           count
);

    logic [COUNT_WIDTH-1:0] running;

    always_comb begin
        packed_row = '0;
        packed_sum = '0;
        running    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (seg_end[k]) begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (running == COUNT_WIDTH'(j)) begin
                        packed_row[j] = seg_row[k];
                        packed_sum[j] = seg_sum[k];
                    end
                end
                running = running + COUNT_WIDTH'(1);
            end
        end
        count = running;
    end

endmodule

// File: rtl/row_accumulator.sv
// Segmented row reduction joining row_ids and products; emits one (row id, sum) per completed row.
// Define ROW_ACCUMULATOR_SATURATE_EN for saturating adds; default build wraps modulo 2^DATA_WIDTH.
module row_accumulator
    import row_acc_pkg::*;
#(
    parameter int DATA_WIDTH  = ACC_WIDTH,
    parameter int PARALLELISM = 8
) (
    input logic          clk,
    input logic          rst_n,
    axi_stream_if.slave  row_ids,
    axi_stream_if.slave  products,
    axi_stream_if.master sum_ids,
    axi_stream_if.master sums
);

    localparam int LANES = PARALLELISM + 1;
    localparam int CW    = $clog2(LANES + 1);

    row_acc_state_e state, next_state;
    carry_t         carry;

    logic in_ready, accept, out_xfer, overflow;
    logic out_valid, out_last, spill_pend;
    logic [PARALLELISM-1:0]                 out_mask;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] out_row, out_sum;
    logic [DATA_WIDTH-1:0]                  spill_row, spill_sum;

    logic [LANES-1:0]                 slot_vld, seg_end;
    logic [LANES-1:0][DATA_WIDTH-1:0] slot_row, slot_val, seg_sum, packed_row, packed_sum;
    logic [CW-1:0]                    count;
    logic                             tail_vld;
    logic [DATA_WIDTH-1:0]            tail_row, tail_sum;

    // products mask/last mirror row_ids by protocol and are not consulted.
    logic unused_inputs;
    assign unused_inputs = ^{products.mask, products.last};

    function automatic logic [DATA_WIDTH-1:0] acc_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
`ifdef ROW_ACCUMULATOR_SATURATE_EN
        return sat_add(a, b);
`else
        return a + b;
`endif
    endfunction

    // Slot 0 is the carry, slots 1..P are the beat lanes; the carry then merges like any lane.
    always_comb begin
        slot_vld    = '0;
        slot_row    = '0;
        slot_val    = '0;
        seg_sum     = '0;
        seg_end     = '0;
        slot_vld[0] = carry.vld;
        slot_row[0] = carry.row;
        slot_val[0] = carry.sum;
        for (int unsigned i = 0; i < PARALLELISM; i++) begin
            slot_vld[i+1] = row_ids.mask[i];
            slot_row[i+1] = row_ids.data[i];
            slot_val[i+1] = products.data[i];
        end
        seg_sum[0] = slot_val[0];
        for (int unsigned k = 1; k < LANES; k++) begin
            seg_sum[k] = (slot_vld[k-1] && slot_row[k-1] == slot_row[k])
                       ? acc_add(seg_sum[k-1], slot_val[k]) : slot_val[k];
        end
        for (int unsigned k = 0; k < PARALLELISM; k++) begin
            seg_end[k] = slot_vld[k] & (slot_vld[k+1] ? (slot_row[k+1] != slot_row[k]) : row_ids.last);
        end
        seg_end[PARALLELISM] = slot_vld[PARALLELISM] & row_ids.last;
        tail_vld = 1'b0;
        tail_row = '0;
        tail_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (slot_vld[k]) begin
                tail_vld = 1'b1;
                tail_row = slot_row[k];
                tail_sum = seg_sum[k];
            end
        end
    end

    segment_compactor #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .COUNT_WIDTH(CW)
    ) u_compactor (
        .seg_end   (seg_end),
        .seg_row   (slot_row),
        .seg_sum   (seg_sum),
        .packed_row(packed_row),
        .packed_sum(packed_sum),
        .count     (count)
    );

    always_comb begin
        out_xfer   = out_valid & sum_ids.ready & sums.ready;
        in_ready   = (state == RUN) & (~out_valid | out_xfer);
        accept     = row_ids.valid & products.valid & in_ready;
        overflow   = (count == CW'(LANES));
        next_state = state;
        case (state)
            RUN:     if (accept && overflow) next_state = FLUSH;
            FLUSH:   if (out_xfer && !spill_pend) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry      <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_mask   <= '0;
            out_row    <= '0;
            out_sum    <= '0;
            spill_pend <= 1'b0;
            spill_row  <= '0;
            spill_sum  <= '0;
        end else if (accept) begin
            carry.vld  <= tail_vld & ~row_ids.last;
            carry.row  <= tail_row;
            carry.sum  <= tail_sum;
            out_valid  <= (count != '0) | row_ids.last;
            out_last   <= row_ids.last & ~overflow;
            for (int unsigned j = 0; j < PARALLELISM; j++) begin
                out_mask[j] <= count > CW'(j);
                out_row[j]  <= packed_row[j];
                out_sum[j]  <= packed_sum[j];
            end
            spill_pend <= overflow;
            spill_row  <= packed_row[PARALLELISM];
            spill_sum  <= packed_sum[PARALLELISM];
        end else if (out_xfer && spill_pend) begin
            out_valid  <= 1'b1;
            out_last   <= 1'b1;
            out_mask   <= PARALLELISM'(1);
            out_row    <= '0;
            out_sum    <= '0;
            out_row[0] <= spill_row;
            out_sum[0] <= spill_sum;
            spill_pend <= 1'b0;
        end else if (out_xfer) begin
            out_valid  <= 1'b0;
        end
    end

    assign row_ids.ready  = in_ready;
    assign products.ready = in_ready;
    assign sum_ids.valid  = out_valid;
    assign sums.valid     = out_valid;
    assign sum_ids.last   = out_last;
    assign sums.last      = out_last;
    assign sum_ids.mask   = out_mask;
    assign sums.mask      = out_mask;
    assign sum_ids.data   = out_row;
    assign sums.data      = out_sum;

endmodule
